// File: rtl/kalman_filter_mac_pipe.sv
// Signed multiply/accumulate pipeline, LAT ce-enabled cycles from sample to out_valid, one sample per cycle.
// No backpressure: ce=0 freezes every stage; the accumulator saturates and raises a sticky ovf.
module kalman_filter_mac_pipe #(
  parameter int AW    = 20,
  parameter int BW    = 19,
  parameter int LAT   = 4,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic signed [AW-1:0]    din0,
  input  logic signed [BW-1:0]    din1,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] dout,
  output logic                    ovf
);
  localparam int PW = AW + BW;
  localparam int SW = PW + 3;
  localparam int D  = LAT - 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [AW-1:0] a_q;
  logic signed [BW-1:0] b_q;
  logic                 v1_q, en1_q, clr1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      en1_q  <= 1'b0;
      clr1_q <= 1'b0;
    end else if (ce) begin
      a_q    <= din0;
      b_q    <= din1;
      v1_q   <= in_valid;
      en1_q  <= acc_en;
      clr1_q <= acc_clr;
    end
  end

  logic signed [PW-1:0] prod_w;
  logic [SW-1:0]        s1_w, fin_w;

  assign prod_w = PW'(a_q) * PW'(b_q);
  assign s1_w   = {v1_q, en1_q, clr1_q, prod_w};

  // Pure delay stages so the final accumulate lands exactly LAT cycles after capture.
  if (D == 0) begin : g_nodly
    assign fin_w = s1_w;
  end else begin : g_dly
    logic [SW-1:0] dly_q [D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < D; i++) dly_q[i] <= '0;
      end else if (ce) begin
        dly_q[0] <= s1_w;
        for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign fin_w = dly_q[D-1];
  end

  logic                    fin_v, fin_en, fin_clr;
  logic signed [PW-1:0]    fin_p;
  logic signed [ACC_W-1:0] ext_w, base_w;
  logic signed [ACC_W:0]   sum_w;
  logic signed [ACC_W-1:0] acc_q, acc_d, dout_q, dout_d;
  logic                    vld_q, ovf_q, ovf_d;

  assign fin_v   = fin_w[SW-1];
  assign fin_en  = fin_w[SW-2];
  assign fin_clr = fin_w[SW-3];
  assign fin_p   = fin_w[PW-1:0];

  always_comb begin
    ext_w  = ACC_W'(fin_p);
    base_w = fin_clr ? '0 : acc_q;
    sum_w  = (ACC_W+1)'(base_w) + (ACC_W+1)'(ext_w);
    acc_d  = acc_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (fin_v) begin
      if (!fin_en) begin
        dout_d = ext_w;
      end else if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        // Carry-out disagrees with the sign bit: clamp toward the sign of the true sum.
        acc_d  = sum_w[ACC_W] ? SAT_MIN : SAT_MAX;
        dout_d = acc_d;
        ovf_d  = 1'b1;
      end else begin
        acc_d  = sum_w[ACC_W-1:0];
        dout_d = acc_d;
        if (fin_clr) ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      acc_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (ce) begin
      vld_q  <= fin_v;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;
endmodule
